// File: rtl/multicycle_controller.sv
// Control FSM for a shared-memory multi-cycle RV32I datapath (lw, sw, R/I-type, beq, jal).
// Outputs decode from the registered state; mem_ready/zero qualify a few enables in-cycle.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               memwrite,
  output logic               adrsrc,
  output logic               irwrite,
  output logic               pcwrite,
  output logic               regwrite,
  output logic [1:0]         alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         resultsrc,
  output logic [1:0]         immsrc,
  output logic               retire,
  output logic               illegal,
  output logic [STATE_W-1:0] dbg_state
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEMADR   = STATE_W'(2),
    S_MEMREAD  = STATE_W'(3),
    S_MEMWB    = STATE_W'(4),
    S_MEMWRITE = STATE_W'(5),
    S_EXECR    = STATE_W'(6),
    S_EXECI    = STATE_W'(7),
    S_JAL      = STATE_W'(8),
    S_ALUWB    = STATE_W'(9),
    S_BEQ      = STATE_W'(10),
    S_TRAP     = STATE_W'(11)
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE && state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR,
      S_EXECI,
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB,
      S_BEQ:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  logic req_c, mw_c, irw_c, pcupd_c, branch_c, rw_c, ret_c;

  always_comb begin
    req_c     = 1'b0;
    mw_c      = 1'b0;
    irw_c     = 1'b0;
    pcupd_c   = 1'b0;
    branch_c  = 1'b0;
    rw_c      = 1'b0;
    ret_c     = 1'b0;
    adrsrc    = 1'b0;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    aluop     = 2'b00;
    resultsrc = 2'b00;
    case (state_q)
      S_FETCH: begin
        req_c     = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irw_c     = mem_ready;
        pcupd_c   = mem_ready;
      end
      // DECODE precomputes oldPC + imm as the branch/jump target.
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      S_MEMREAD: begin
        req_c  = 1'b1;
        adrsrc = 1'b1;
      end
      S_MEMWB: begin
        resultsrc = 2'b01;
        rw_c      = 1'b1;
        ret_c     = 1'b1;
      end
      S_MEMWRITE: begin
        req_c  = 1'b1;
        mw_c   = 1'b1;
        adrsrc = 1'b1;
        ret_c  = mem_ready;
      end
      S_EXECR: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
      end
      S_EXECI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
      end
      S_JAL: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
        pcupd_c = 1'b1;
      end
      S_ALUWB: begin
        rw_c  = 1'b1;
        ret_c = 1'b1;
      end
      S_BEQ: begin
        alusrca  = 2'b10;
        aluop    = 2'b01;
        branch_c = 1'b1;
        ret_c    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  // Reset blanks every side-effecting enable in the same cycle it is high.
  assign mem_req   = req_c & ~reset;
  assign memwrite  = mw_c & ~reset;
  assign irwrite   = irw_c & ~reset;
  assign pcwrite   = (pcupd_c | (branch_c & zero)) & ~reset;
  assign regwrite  = rw_c & ~reset;
  assign retire    = ret_c & ~reset;
  assign illegal   = illegal_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: state sequences, enables, handshake waits and trap.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite, retire, illegal;
  logic [1:0] alusrca, alusrcb, aluop, resultsrc, immsrc;
  logic [3:0] dbg_state;

  int errors = 0;
  int checks = 0;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .adrsrc(adrsrc), .irwrite(irwrite),
    .pcwrite(pcwrite), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .resultsrc(resultsrc), .immsrc(immsrc), .retire(retire),
    .illegal(illegal), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    op = 7'b0000011; mem_ready = 1'b1; zero = 1'b0; reset = 1'b1;
    tick(); tick();
    checks++; if (dbg_state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    checks++; if ({memwrite, irwrite, pcwrite, regwrite, mem_req, retire} !== 6'b0) begin errors++;
      $display("FAIL reset_enables: got %b want 000000", {memwrite, irwrite, pcwrite, regwrite, mem_req, retire}); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    reset = 1'b0; #1;
    checks++; if ({mem_req, irwrite, pcwrite} !== 3'b111) begin errors++;
      $display("FAIL fetch_enables: got %b want 111", {mem_req, irwrite, pcwrite}); end
    tick(); tick(); tick();
    checks++; if (dbg_state !== 4'd3) begin errors++; $display("FAIL reach_memread: got %0d want 3", dbg_state); end
    reset = 1'b1; #1;
    checks++; if ({memwrite, regwrite, pcwrite, irwrite, mem_req} !== 5'b0) begin errors++;
      $display("FAIL reset_mid_enables: got %b want 00000", {memwrite, regwrite, pcwrite, irwrite, mem_req}); end
    tick();
    checks++; if (dbg_state !== 4'd0) begin errors++; $display("FAIL reset_mid_state: got %0d want 0", dbg_state); end
    checks++; if ({memwrite, regwrite, pcwrite, irwrite, mem_req} !== 5'b0) begin errors++;
      $display("FAIL reset_hold_enables: got %b want 00000", {memwrite, regwrite, pcwrite, irwrite, mem_req}); end
    reset = 1'b0; #1;
  endtask

  task automatic test_fetch_wait();
    do_reset();
    op = 7'b0110011; mem_ready = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if ({dbg_state, mem_req, irwrite, pcwrite} !== {4'd0, 3'b100}) begin errors++;
        $display("FAIL fetch_wait[%0d]: got st=%0d req/ir/pc=%b want st=0 100", i, dbg_state, {mem_req, irwrite, pcwrite}); end
      tick();
    end
    mem_ready = 1'b1; #1;
    checks++; if ({dbg_state, irwrite} !== {4'd0, 1'b1}) begin errors++;
      $display("FAIL fetch_ready: got st=%0d ir=%b want st=0 ir=1", dbg_state, irwrite); end
    tick();
    checks++; if (dbg_state !== 4'd1) begin errors++; $display("FAIL rtype_decode: got %0d want 1", dbg_state); end
    tick();
    checks++; if ({dbg_state, alusrca, alusrcb, aluop} !== {4'd6, 2'b10, 2'b00, 2'b10}) begin errors++;
      $display("FAIL rtype_exec: got st=%0d a=%b b=%b op=%b want 6 10 00 10", dbg_state, alusrca, alusrcb, aluop); end
    tick();
    checks++; if ({dbg_state, regwrite, retire, resultsrc} !== {4'd9, 1'b1, 1'b1, 2'b00}) begin errors++;
      $display("FAIL rtype_wb: got st=%0d rw=%b ret=%b rs=%b want 9 1 1 00", dbg_state, regwrite, retire, resultsrc); end
    tick();
    checks++; if (dbg_state !== 4'd0) begin errors++; $display("FAIL rtype_done: got %0d want 0", dbg_state); end
  endtask

  task automatic test_itype();
    logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd7, 4'd9, 4'd0};
    do_reset();
    op = 7'b0010011; mem_ready = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (dbg_state !== exp_s[i]) begin errors++;
        $display("FAIL itype_seq[%0d]: got %0d want %0d", i, dbg_state, exp_s[i]); end
      if (i == 2) begin
        checks++; if ({alusrca, alusrcb, aluop} !== 6'b100110) begin errors++;
          $display("FAIL itype_exec: got a=%b b=%b op=%b want 10 01 10", alusrca, alusrcb, aluop); end
      end
      tick();
    end
  endtask

  task automatic test_lw();
    logic [3:0] exp_s [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    int retires = 0;
    do_reset();
    op = 7'b0000011; mem_ready = 1'b1; #1;
    checks++; if (immsrc !== 2'b00) begin errors++; $display("FAIL lw_immsrc: got %b want 00", immsrc); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (dbg_state !== exp_s[i]) begin errors++;
        $display("FAIL lw_seq[%0d]: got %0d want %0d", i, dbg_state, exp_s[i]); end
      checks++; if (regwrite !== (exp_s[i] == 4'd4)) begin errors++;
        $display("FAIL lw_regwrite[%0d]: got %b want %b", i, regwrite, exp_s[i] == 4'd4); end
      if (exp_s[i] == 4'd4) begin
        checks++; if (resultsrc !== 2'b01) begin errors++; $display("FAIL lw_resultsrc: got %b want 01", resultsrc); end
      end
      if (exp_s[i] == 4'd3) begin
        checks++; if ({mem_req, adrsrc, memwrite} !== 3'b110) begin errors++;
          $display("FAIL lw_memread: got req/adr/mw=%b want 110", {mem_req, adrsrc, memwrite}); end
      end
      if (i < 5) retires += int'(retire);
      tick();
    end
    checks++; if (retires != 1) begin errors++; $display("FAIL lw_retire_count: got %0d want 1", retires); end
  endtask

  task automatic test_sw();
    int held = 0;
    do_reset();
    op = 7'b0100011; mem_ready = 1'b1; #1;
    checks++; if (immsrc !== 2'b01) begin errors++; $display("FAIL sw_immsrc: got %b want 01", immsrc); end
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({dbg_state, memwrite, mem_req, adrsrc, retire} !== {4'd5, 4'b1110}) begin errors++;
        $display("FAIL sw_wait[%0d]: got st=%0d mw/req/adr/ret=%b want 5 1110", i, dbg_state, {memwrite, mem_req, adrsrc, retire}); end
      if (dbg_state == 4'd5) held++;
      tick();
    end
    mem_ready = 1'b1; #1;
    checks++; if ({dbg_state, memwrite, mem_req, retire} !== {4'd5, 3'b111}) begin errors++;
      $display("FAIL sw_ready: got st=%0d mw/req/ret=%b want 5 111", dbg_state, {memwrite, mem_req, retire}); end
    if (dbg_state == 4'd5) held++;
    tick();
    checks++; if (dbg_state !== 4'd0) begin errors++; $display("FAIL sw_done: got %0d want 0", dbg_state); end
    checks++; if (held != 4) begin errors++; $display("FAIL sw_held: got %0d want 4", held); end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      do_reset();
      op = 7'b1100011; mem_ready = 1'b1; zero = 1'b0; #1;
      checks++; if (immsrc !== 2'b10) begin errors++; $display("FAIL beq_immsrc: got %b want 10", immsrc); end
      tick(); tick();
      zero = z[0]; #1;
      checks++; if ({dbg_state, pcwrite, aluop, retire} !== {4'd10, z[0], 2'b01, 1'b1}) begin errors++;
        $display("FAIL beq_z%0d: got st=%0d pc=%b op=%b ret=%b want 10 %0d 01 1", z, dbg_state, pcwrite, aluop, retire, z); end
      tick();
      zero = 1'b0;
      checks++; if (dbg_state !== 4'd0) begin errors++; $display("FAIL beq_done_z%0d: got %0d want 0", z, dbg_state); end
    end
  endtask

  task automatic test_jal();
    logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd8, 4'd9, 4'd0};
    do_reset();
    op = 7'b1101111; mem_ready = 1'b1; #1;
    checks++; if (immsrc !== 2'b11) begin errors++; $display("FAIL jal_immsrc: got %b want 11", immsrc); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (dbg_state !== exp_s[i]) begin errors++;
        $display("FAIL jal_seq[%0d]: got %0d want %0d", i, dbg_state, exp_s[i]); end
      if (i == 2) begin
        checks++; if ({pcwrite, regwrite, alusrca, alusrcb} !== 6'b100110) begin errors++;
          $display("FAIL jal_state8: got pc/rw=%b a=%b b=%b want 10 01 10", {pcwrite, regwrite}, alusrca, alusrcb); end
      end
      if (i == 3) begin
        checks++; if ({pcwrite, regwrite} !== 2'b01) begin errors++;
          $display("FAIL jal_state9: got pc/rw=%b want 01", {pcwrite, regwrite}); end
      end
      tick();
    end
  endtask

  task automatic test_trap();
    do_reset();
    op = 7'b1111111; mem_ready = 1'b1; zero = 1'b1; #1;
    tick();
    checks++; if ({dbg_state, illegal} !== {4'd1, 1'b0}) begin errors++;
      $display("FAIL trap_decode: got st=%0d ill=%b want 1 0", dbg_state, illegal); end
    tick();
    for (int i = 0; i < 12; i++) begin
      mem_ready = i[0]; #1;
      checks++; if ({dbg_state, illegal, memwrite, irwrite, pcwrite, regwrite, mem_req, retire} !== {4'd11, 7'b1000000}) begin errors++;
        $display("FAIL trap_hold[%0d]: got st=%0d ill=%b en=%b want 11 1 000000", i, dbg_state, illegal,
                 {memwrite, irwrite, pcwrite, regwrite, mem_req, retire}); end
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_ready = 1'b0; zero = 1'b0; #1;
    checks++; if ({dbg_state, illegal} !== {4'd0, 1'b0}) begin errors++;
      $display("FAIL trap_exit: got st=%0d ill=%b want 0 0", dbg_state, illegal); end
  endtask

  initial begin
    reset = 1'b1; op = 7'd0; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_fetch_wait();
    test_itype();
    test_lw();
    test_sw();
    test_beq();
    test_jal();
    test_trap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences a shared-memory multi-cycle RV32I datapath (lw, sw, R-type, I-type ALU, beq, jal).
- Replaces the single-cycle control path: one instruction takes 3-5 states plus memory wait cycles.
- Drives enables and mux selects, and emits aluop for the existing ALU decoder.
- Includes a req/ready handshake with the unified instruction/data memory.

Parameters:
- STATE_W, 4, width of state register and dbg_state port.

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-high
- op  input  7  opcode from instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- mem_req  output  1  memory access request
- memwrite  output  1  memory write enable
- adrsrc  output  1  memory address select: 0=PC, 1=result
- irwrite  output  1  instruction register / oldPC load enable
- pcwrite  output  1  PC load enable
- regwrite  output  1  register file write enable
- alusrca  output  2  ALU A select: 00=PC, 01=oldPC, 10=rs1
- alusrcb  output  2  ALU B select: 00=rs2, 01=imm, 10=const 4
- aluop  output  2  to ALU decoder: 00=add, 01=sub, 10=funct-decoded
- resultsrc  output  2  result select: 00=ALUOut, 01=data reg, 10=ALU result
- immsrc  output  2  combinational from op: lw/I-type 00, sw 01, beq 10, jal 11, other 00
- retire  output  1  one-cycle pulse when an instruction completes
- illegal  output  1  sticky illegal-opcode flag
- dbg_state  output  STATE_W  current state encoding

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, JAL=8, ALUWB=9, BEQ=10, TRAP=11. Codes 12-15 go to FETCH.
- Reset: a clk edge with reset=1 loads FETCH and clears illegal. While reset=1, memwrite, irwrite, pcwrite, regwrite, mem_req and retire are all forced to 0. Reset wins over every other event, including mid-instruction and in TRAP.
- Defaults: every output not listed for a state is 0.
- pcwrite = pcupdate | (branch & zero), where pcupdate and branch are internal.
- FETCH:
  - Outputs: mem_req=1, adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10.
  - irwrite and pcupdate equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alusrca=01, alusrcb=01, aluop=00 (branch/jump target precompute).
  - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; any other op -> TRAP.
- MEMADR: alusrca=10, alusrcb=01, aluop=00. Next: op=0000011 -> MEMREAD, otherwise MEMWRITE.
- MEMREAD: mem_req=1, adrsrc=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: resultsrc=01, regwrite=1, retire=1. Next: FETCH.
- MEMWRITE:
  - Outputs: mem_req=1, memwrite=1, adrsrc=1.
  - memwrite stays asserted for every wait cycle; memory commits on the mem_ready cycle.
  - retire=mem_ready. Goes to FETCH on mem_ready.
- EXECR: alusrca=10, alusrcb=00, aluop=10. Next: ALUWB.
- EXECI: alusrca=10, alusrcb=01, aluop=10. Next: ALUWB.
- JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1. Next: ALUWB.
- ALUWB: resultsrc=00, regwrite=1, retire=1. Next: FETCH.
- BEQ:
  - Outputs: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1, retire=1.
  - pcwrite follows zero. Next: FETCH.
- TRAP:
  - All enables are 0 and illegal=1.
  - Held indefinitely; only reset exits.
  - illegal is set on the DECODE->TRAP edge, so it is visible in the first TRAP cycle.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- mem_req is never asserted in two consecutive accesses without a state change between them, except while waiting for mem_ready.
- Latency with mem_ready tied to 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type, I-type, jal: 4 cycles
  - beq: 3 cycles
- Each memory wait cycle adds 1 cycle to these counts.

Test Plan:
- Reset asserted in MEMREAD (dbg_state=3) -> next cycle dbg_state=0; memwrite, regwrite, pcwrite and irwrite are 0 throughout reset.
- mem_ready=1 always; op=0000011 -> dbg_state sequence 0,1,2,3,4,0. regwrite=1 and resultsrc=01 only in state 4; retire pulses once; immsrc=00.
- op=0100011 with mem_ready low for 3 cycles in MEMWRITE -> state 5 held 4 cycles with memwrite=1 and mem_req=1. retire=1 only on the ready cycle; immsrc=01.
- op=1100011: zero=1 gives pcwrite=1 in state 10; zero=0 gives pcwrite=0 in state 10. Both take 3 cycles and aluop=01.
- op=1101111 -> states 0,1,8,9,0. pcwrite=1 in state 8, regwrite=1 in state 9, immsrc=11.
- op=1111111 -> state 11 with illegal=1 and all enables 0 for 10+ cycles. Asserting reset returns dbg_state to 0 and clears illegal.
